turbo_itl_top: RTL and testbench

TURBO_ITL_TOP -- requirements
Module: turbo_itl_top

---
 rtl/turbo_itl_top.sv | 181 ++++++++++++++++++
 tb/tb_turbo_itl_top.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/turbo_itl_top.sv
// turbo_itl_top: 64 x 1-bit frame buffer for a turbo-code interleaver.
// Serial bits are written in natural order. A request strobe reads the
// frame out twice in parallel: once in natural order on rdata, and once in
// bit-reversed (optionally XOR-scrambled) order on rdata_itl.
//
// Build option: define ITL_XOR_SCRAMBLE_EN to XOR the reversed index with
// the latched seed masked to the frame length. When it is undefined, the
// permutation is a plain bit reversal and the seed bits are ignored.

module turbo_itl_top (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] link_id,
  input  logic       din,
  input  logic       din_vld,
  input  logic       request,
  output logic       rdata,
  output logic       rdata_itl
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  logic [63:0] buf_r;
  logic [5:0]  wr_ptr_r;
  logic [5:0]  rd_cnt_r;
  logic [1:0]  ksel_r;        // latched frame-length select
  logic [5:0]  kmax_rd_s;     // K-1 of the latched frame
  logic [5:0]  kmax_wr_s;     // K-1 governing the current write
  logic        wr_en_s;
  logic        last_s;
  logic [5:0]  pi_s;
  logic        latch_s;

`ifdef ITL_XOR_SCRAMBLE_EN
  logic [5:0]  seed_r;
`else
  logic [3:0]  seed_unused_s;
  assign seed_unused_s = link_id[5:2];
`endif

  // Returns K-1 for a frame-length select code.
  function automatic logic [5:0] kmax_f(input logic [1:0] sel);
    logic [5:0] km;
    case (sel)
      2'b00:   km = 6'd7;
      2'b01:   km = 6'd15;
      2'b10:   km = 6'd31;
      default: km = 6'd63;
    endcase
    return km;
  endfunction

  // Reverses the low n = log2(K) bits of idx; upper bits come back as zero.
  function automatic logic [5:0] bitrev_f(input logic [5:0] idx, input logic [1:0] sel);
    logic [5:0] rev;
    logic [5:0] res;
    rev = {idx[0], idx[1], idx[2], idx[3], idx[4], idx[5]};
    case (sel)
      2'b00:   res = {3'b000, rev[5:3]};
      2'b01:   res = {2'b00,  rev[5:2]};
      2'b10:   res = {1'b0,   rev[5:1]};
      default: res = rev;
    endcase
    return res;
  endfunction

  // Write qualification, frame-length decode and interleaved read address.
  always_comb begin
    wr_en_s   = 1'b0;
    kmax_wr_s = 6'd0;
    latch_s   = 1'b0;
    kmax_rd_s = kmax_f(ksel_r);
    last_s    = (rd_cnt_r == kmax_rd_s);
    // Request wins over a simultaneous write; nothing is written in READ.
    if ((state_r == IDLE) && din_vld && !request) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
    // The first bit of a frame takes its length from the incoming link_id.
    if (wr_ptr_r == 6'd0) begin
      latch_s   = wr_en_s;
      kmax_wr_s = kmax_f(link_id[1:0]);
    end else begin
      latch_s   = 1'b0;
      kmax_wr_s = kmax_rd_s;
    end
`ifdef ITL_XOR_SCRAMBLE_EN
    pi_s = bitrev_f(rd_cnt_r, ksel_r) ^ (seed_r & kmax_rd_s);
`else
    pi_s = bitrev_f(rd_cnt_r, ksel_r);
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: one burst of K cycles per accepted request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (request) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: begin
        if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = READ;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Frame buffer write path and frame parameter latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_r    <= 64'd0;
      wr_ptr_r <= 6'd0;
      ksel_r   <= 2'b00;
`ifdef ITL_XOR_SCRAMBLE_EN
      seed_r   <= 6'd0;
`endif
    end else begin
      if (wr_en_s) begin
        buf_r[wr_ptr_r] <= din;
        if (wr_ptr_r == kmax_wr_s) begin
          wr_ptr_r <= 6'd0;
        end else begin
          wr_ptr_r <= wr_ptr_r + 6'd1;
        end
      end
      if (latch_s) begin
        ksel_r <= link_id[1:0];
`ifdef ITL_XOR_SCRAMBLE_EN
        seed_r <= link_id;
`endif
      end
    end
  end

  // Readout counter and registered outputs; outputs idle low outside a burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_r  <= 6'd0;
      rdata     <= 1'b0;
      rdata_itl <= 1'b0;
    end else begin
      case (state_r)
        READ: begin
          rdata     <= buf_r[rd_cnt_r];
          rdata_itl <= buf_r[pi_s];
          rd_cnt_r  <= rd_cnt_r + 6'd1;
        end
        default: begin
          rdata     <= 1'b0;
          rdata_itl <= 1'b0;
          rd_cnt_r  <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_itl_top.sv
// Self-checking bench for turbo_itl_top. A reference model of the buffer,
// write pointer and latched frame parameters predicts each readout burst;
// expected output pairs are queued when the request is driven and compared
// one per clock against the DUT outputs (empty queue means both outputs 0).

module tb_turbo_itl_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] link_id;
  logic       din;
  logic       din_vld;
  logic       request;
  logic       rdata;
  logic       rdata_itl;

  typedef struct packed {
    logic nat;
    logic itl;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;

  // Reference model state
  logic       m_mem[64];
  int         m_wptr;
  logic [5:0] m_link;
  int         busy;

  always #5 clk = ~clk;

  turbo_itl_top dut (
    .clk       (clk),
    .rst       (rst),
    .link_id   (link_id),
    .din       (din),
    .din_vld   (din_vld),
    .request   (request),
    .rdata     (rdata),
    .rdata_itl (rdata_itl)
  );

  function automatic int klen(input logic [1:0] s);
    return 8 << s;
  endfunction

  // Interleaver index computed bit by bit from the definition.
  function automatic int pi_model(input int i, input logic [5:0] lnk);
    int k;
    int n;
    int r;
    k = 8 << lnk[1:0];
    n = 3 + int'(lnk[1:0]);
    r = 0;
    for (int b = 0; b < n; b++) begin
      if (((i >> b) & 1) == 1) r = r | (1 << (n - 1 - b));
    end
`ifdef ITL_XOR_SCRAMBLE_EN
    r = r ^ (int'(lnk) & (k - 1));
`endif
    return r;
  endfunction

  // Compare DUT outputs with the scoreboard just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '0;
    vectors++;
    assert (rdata === e.nat) else begin
      miscompares++;
      $error("FAIL rdata: observed %b expected %b at %0t", rdata, e.nat, $time);
    end
    vectors++;
    assert (rdata_itl === e.itl) else begin
      miscompares++;
      $error("FAIL rdata_itl: observed %b expected %b at %0t", rdata_itl, e.itl, $time);
    end
  end

  task automatic clear_model();
    for (int j = 0; j < 64; j++) m_mem[j] = 1'b0;
    m_wptr = 0;
    m_link = 6'd0;
    busy   = 0;
    exp_q.delete();
  endtask

  // One clock of stimulus; the model mirrors what the design must accept.
  task automatic cycle(input logic [5:0] lid, input logic d, input logic dv, input logic req);
    int k;
    exp_t e;
    @(negedge clk);
    rst     = 1'b0;
    link_id = lid;
    din     = d;
    din_vld = dv;
    request = req;
    if (busy > 0) begin
      busy--;
    end else if (req) begin
      k = klen(m_link[1:0]);
      exp_q.push_back('0);
      for (int i = 0; i < k; i++) begin
        e.nat = m_mem[i];
        e.itl = m_mem[pi_model(i, m_link)];
        exp_q.push_back(e);
      end
      busy = k;
    end else if (dv) begin
      if (m_wptr == 0) m_link = lid;
      m_mem[m_wptr] = d;
      k = klen(m_link[1:0]);
      m_wptr = (m_wptr == k - 1) ? 0 : m_wptr + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    din     = 1'b0;
    din_vld = 1'b0;
    request = 1'b0;
    clear_model();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cycle(link_id, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_bits(input logic [5:0] lid, input logic [63:0] bits, input int n);
    for (int j = 0; j < n; j++) cycle(lid, bits[j], 1'b1, 1'b0);
  endtask

  initial begin
    logic [63:0] pat;
    logic [5:0]  rlid;
    rst     = 1'b1;
    link_id = 6'd0;
    din     = 1'b0;
    din_vld = 1'b0;
    request = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    idle(2);

    // Natural and interleaved order, K=8 with masked seed 0: 1,0,1,0,1,0,1,1
    pat = 64'b1101_0101;
    write_bits(6'h20, pat, 8);
    cycle(6'h20, 1'b0, 1'b0, 1'b1);
    idle(10);

    // Second request and din pulses during a burst are ignored
    cycle(6'h20, 1'b0, 1'b0, 1'b1);
    cycle(6'h3F, 1'b0, 1'b1, 1'b0);
    cycle(6'h3F, 1'b0, 1'b1, 1'b0);
    cycle(6'h3F, 1'b1, 1'b1, 1'b0);
    cycle(6'h20, 1'b0, 1'b0, 1'b1);
    cycle(6'h3F, 1'b0, 1'b1, 1'b0);
    cycle(6'h3F, 1'b0, 1'b1, 1'b0);
    idle(6);
    cycle(6'h20, 1'b0, 1'b0, 1'b1);
    idle(10);

    // Wrap-around: 10 bits with K=8, then one more lands at index 2
    pat = 64'b00_0101_0011;
    write_bits(6'h00, pat, 10);
    cycle(6'h00, 1'b1, 1'b1, 1'b0);
    // Request with simultaneous din: din is dropped
    cycle(6'h00, 1'b1, 1'b1, 1'b1);
    idle(10);

    // Reset mid-burst, then a readout of the cleared buffer
    do_reset();
    pat = {$urandom, $urandom};
    write_bits(6'h35, pat, 16);
    cycle(6'h35, 1'b0, 1'b0, 1'b1);
    idle(4);
    do_reset();
    idle(2);
    cycle(6'h00, 1'b0, 1'b0, 1'b1);
    idle(10);

    // K=64, seed 3: only buffer[3] set
    do_reset();
    pat = 64'd8;
    write_bits(6'h03, pat, 64);
    cycle(6'h03, 1'b0, 1'b0, 1'b1);
    idle(66);

    // Random frames across lengths and seeds
    for (int r = 0; r < 4; r++) begin
      do_reset();
      rlid = 6'($urandom);
      pat  = {$urandom, $urandom};
      write_bits(rlid, pat, klen(rlid[1:0]) + 3);
      cycle(rlid, 1'b0, 1'b0, 1'b1);
      idle(klen(rlid[1:0]) + 3);
    end

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
